// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Quotient returned on divide-by-zero is all ones at the operand width;
  // users slice this down to their own width.
  localparam int unsigned     MaxWidth           = 64;
  localparam logic [MaxWidth-1:0] DivZeroQuotientAll = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the ALU control FSM and the divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // ALU control side: issues operations, consumes results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_adder.sv
// ALU adder: sum = x + (y, inverted in subtract mode) + carry_in.
module seq_divider_adder #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] y_eff;

  // Subtract mode is two's complement: invert y here, caller supplies carry_in=1.
  always_comb begin
    y_eff = y ^ {WIDTH{sub}};
    sum   = x + y_eff + {{(WIDTH-1){1'b0}}, carry_in};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  seq_divider_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]  LastCnt         = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DivZeroQuotient = DivZeroQuotientAll[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;      // partial remainder
  logic [WIDTH-1:0] q_q, q_d;      // dividend out / quotient in
  logic [WIDTH:0]   m_q, m_d;      // zero-extended divisor
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [2*WIDTH:0] aq_sh;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   a_iter;
  logic [WIDTH-1:0] q_iter;

  // Shift {A,Q} left by one; the vacated Q lsb becomes the new quotient bit.
  always_comb begin
    aq_sh = {a_q, q_q} << 1;
    a_sh  = aq_sh[2*WIDTH:WIDTH];
    q_sh  = aq_sh[WIDTH-1:0];
  end

  // Trial subtraction T = A' - M on the shared adder.
  seq_divider_adder #(
    .WIDTH (WIDTH + 1)
  ) u_adder (
    .x        (a_sh),
    .y        (m_q),
    .sub      (1'b1),
    .carry_in (1'b1),
    .sum      (t)
  );

  // Negative trial result (sign bit set) means restore A and shift in a 0.
  always_comb begin
    a_iter = t[WIDTH] ? a_sh : t;
    q_iter = q_sh | {{(WIDTH-1){1'b0}}, ~t[WIDTH]};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            a_d     = '0;
            q_d     = bus.dividend;
            m_d     = {1'b0, bus.divisor};
            cnt_d   = '0;
            state_d = StRun;
          end else begin
            quot_d  = DivZeroQuotient;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StRun: begin
        a_d   = a_iter;
        q_d   = q_iter;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          quot_d  = q_iter;
          rem_d   = a_iter[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Status decoded from state; results straight from holding registers.
  always_comb begin
    bus.busy        = (state_q == StRun);
    bus.done        = (state_q == StDone);
    bus.quotient    = quot_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_q;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider for the ALU datapath.
- Performs the inverse of the multiply path through repeated conditional subtraction. Each iteration uses the ALU adder in subtract mode.
- Accepts one operation per start pulse and returns the quotient and remainder with a done pulse.
- Sits beside the adder in the ALU execute stage; the ALU control FSM drives start and consumes done.

Parameters:
- WIDTH, 8, operand width in bits; quotient and remainder are WIDTH bits; internal partial remainder is WIDTH+1 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend, sampled with accepted start
- divisor  input  WIDTH  unsigned divisor, sampled with accepted start
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse: results valid
- quotient  output  WIDTH  result quotient
- remainder  output  WIDTH  result remainder
- div_by_zero  output  1  set with done when divisor was 0

Behaviour:
- Reset (rst_b=0, asynchronous):
  - state=IDLE; all registers, busy, done, quotient, remainder and div_by_zero are 0.
  - Takes effect immediately, including mid-operation. The in-flight result is discarded and no done is issued.
- Registers:
  - A: WIDTH+1 bits, partial remainder.
  - Q: WIDTH bits, dividend shifting out and quotient shifting in.
  - M: WIDTH+1 bits, zero-extended divisor.
  - cnt: counts iterations, 0..WIDTH-1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and divisor!=0 -> load A=0, Q=dividend, M={0,divisor}, cnt=0 -> RUN.
  - start=1 and divisor=0 -> load quotient=all ones, remainder=dividend, div_by_zero=1 -> DONE. No iterations.
  - start=0 -> stay.
- RUN: one iteration per cycle.
  - {A,Q} shifted left by 1 into {A',Q'}.
  - T = A' + ~M + 1, using the adder at width WIDTH+1 with carry_in=1.
  - If T[WIDTH]=0: A=T and Q={Q'[WIDTH-1:1],1}.
  - Else: A=A' (restore) and Q={Q'[WIDTH-1:1],0}.
  - cnt increments.
  - On the iteration with cnt=WIDTH-1: quotient=final Q, remainder=final A[WIDTH-1:0], div_by_zero=0 -> DONE.
- DONE:
  - done=1 for exactly this one cycle, then unconditionally -> IDLE.
  - start is ignored in DONE, so the minimum issue interval is WIDTH+2 cycles.
- Latency:
  - Start accepted at edge k; done is high in the cycle following edge k+WIDTH.
  - For div-by-zero, done is high in the cycle following edge k.
- busy: 1 exactly in RUN.
- start while busy or in DONE: ignored; operands are not resampled.
- Outputs:
  - quotient, remainder and div_by_zero hold their last values until the next accepted start.
  - On the next accepted start they are not cleared; they update only on completion.
  - div_by_zero updates together with quotient and remainder.
- Arithmetic:
  - All operations are unsigned.
  - A never exceeds M-1 after an iteration. The WIDTH+1 width guarantees no overflow of the shifted A.
  - Adder carry-out is unused; sign is taken from T[WIDTH].
- Invariant at done (non-zero divisor): dividend = quotient*divisor + remainder, with remainder < divisor.

Decomposition:
- Shared ALU package holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the div-by-zero quotient constant (all ones at WIDTH).
- One sub-module: instantiate the existing adder with width=WIDTH+1, carry_in tied to 1, x=A', y=M, sum=T. No separate subtractor is written.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, start 1 cycle -> busy high 8 cycles; done pulse 9 cycles after start; quotient=14, remainder=2, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5. Then dividend=255, divisor=255 -> quotient=1, remainder=0.
- dividend=200, divisor=0 -> busy never high; done in the cycle after start; quotient=255, remainder=200, div_by_zero=1. A following 100/7 clears div_by_zero at its done.
- Accepted 100/7, then start with 50/5 held high during RUN and DONE -> only the 100/7 result (14, 2) appears. The second op is accepted only when start is still high in IDLE, yielding 10, 0.
- rst_b low at iteration 4 of 100/7 -> all outputs 0 immediately and no done pulse. After release, 60/4 -> quotient=15, remainder=0.
- Random sweep, 10k ops, WIDTH=8 and WIDTH=16 -> every done satisfies the quotient/remainder invariant. Latency is exactly WIDTH+1 cycles for non-zero divisors.
